uart_axis_cfg_bridge: RTL and testbench

// Runtime-configurable UART <-> AXI-stream bridge, successor to the fixed-divisor 8N1 bridge.

---
 rtl/uart_axis_cfg_bridge.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_uart_axis_cfg_bridge.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axis_cfg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_axis_cfg_bridge
// Description : UART <-> AXI-stream bridge with runtime baud divisor, data
//               width, parity and stop-bit selection. RX and TX are each
//               buffered by a small FIFO. RX parity/framing errors are
//               reported per byte on m_axis_tuser.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_axis_cfg_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [3:0]            cfg_data_bits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]            m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic                  tx_busy,
  output logic                  rx_overrun
);

  localparam int                    AW         = $clog2(FIFO_DEPTH);
  localparam int                    RW         = DATA_WIDTH + 2;
  localparam logic [3:0]            C_MAX_BITS = 4'(DATA_WIDTH);
  localparam logic [DIV_WIDTH-1:0]  C_MIN_DIV  = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0]  C_ONE      = DIV_WIDTH'(1);
  localparam logic [AW:0]           C_PTR_ONE  = (AW+1)'(1);
  localparam logic [DATA_WIDTH-1:0] C_DATA_ONE = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Effective configuration (clamped); sampled by each FSM at frame start
  // ---------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0]  div_eff;
  logic [3:0]            nbits_eff;
  logic                  par_en_eff;
  logic                  par_odd_eff;
  logic [DATA_WIDTH-1:0] data_mask;

  // Clamp divisor and data width, decode parity mode
  always_comb begin
    div_eff = (cfg_div < C_MIN_DIV) ? C_MIN_DIV : cfg_div;
    if (cfg_data_bits < 4'd5)             nbits_eff = 4'd5;
    else if (cfg_data_bits > C_MAX_BITS)  nbits_eff = C_MAX_BITS;
    else                                  nbits_eff = cfg_data_bits;
    par_en_eff  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    par_odd_eff = (cfg_parity == 2'b10);
    data_mask   = ~({DATA_WIDTH{1'b1}} << nbits_eff);
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AW:0]           tx_wr_q, tx_rd_q;
  logic                  tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  assign tx_empty      = (tx_wr_q == tx_rd_q);
  assign tx_full       = (tx_wr_q[AW] != tx_rd_q[AW]) &&
                         (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign s_axis_tready = !tx_full && !rst;
  assign tx_push       = s_axis_tvalid && s_axis_tready;
  assign tx_head       = tx_mem_q[tx_rd_q[AW-1:0]] & data_mask;

  // TX FIFO storage (no reset needed, occupancy is tracked by the pointers)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= s_axis_tdata;
  end

  // TX FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + C_PTR_ONE;
      if (tx_pop)  tx_rd_q <= tx_rd_q + C_PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  state_t                tx_state_q;
  logic [DIV_WIDTH-1:0]  tx_cnt_q, tx_div_q;
  logic [3:0]            tx_bit_q, tx_nbits_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  logic                  tx_par_en_q, tx_par_q, tx_stop2_q, tx_stop_second_q, tx_q;
  logic                  tx_bit_end, tx_frame_end;

  assign tx_bit_end   = (tx_cnt_q == tx_div_q - C_ONE);
  assign tx_frame_end = (tx_state_q == ST_STOP) && tx_bit_end &&
                        (!tx_stop2_q || tx_stop_second_q);
  // Popping at the end of the last stop bit gives gap-free back-to-back frames
  assign tx_pop       = !tx_empty && ((tx_state_q == ST_IDLE) || tx_frame_end);
  assign uart_tx      = tx_q;
  assign tx_busy      = (tx_state_q != ST_IDLE) || !tx_empty;

  // Serialise one frame per FIFO entry, each bit held for tx_div_q cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q       <= ST_IDLE;
      tx_cnt_q         <= '0;
      tx_div_q         <= C_MIN_DIV;
      tx_bit_q         <= '0;
      tx_nbits_q       <= 4'd8;
      tx_shift_q       <= '0;
      tx_par_en_q      <= 1'b0;
      tx_par_q         <= 1'b0;
      tx_stop2_q       <= 1'b0;
      tx_stop_second_q <= 1'b0;
      tx_q             <= 1'b1;
    end else if (tx_pop) begin
      tx_state_q       <= ST_START;
      tx_cnt_q         <= '0;
      tx_div_q         <= div_eff;
      tx_bit_q         <= '0;
      tx_nbits_q       <= nbits_eff;
      tx_shift_q       <= tx_head;
      tx_par_en_q      <= par_en_eff;
      tx_par_q         <= (^tx_head) ^ par_odd_eff;
      tx_stop2_q       <= cfg_stop2;
      tx_stop_second_q <= 1'b0;
      tx_q             <= 1'b0;
    end else if (tx_state_q != ST_IDLE) begin
      if (!tx_bit_end) begin
        tx_cnt_q <= tx_cnt_q + C_ONE;
      end else begin
        tx_cnt_q <= '0;
        case (tx_state_q)
          ST_START: begin
            tx_state_q <= ST_DATA;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
          ST_DATA: begin
            if (tx_bit_q == tx_nbits_q - 4'd1) begin
              if (tx_par_en_q) begin
                tx_state_q <= ST_PARITY;
                tx_q       <= tx_par_q;
              end else begin
                tx_state_q <= ST_STOP;
                tx_q       <= 1'b1;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 4'd1;
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
          ST_PARITY: begin
            tx_state_q <= ST_STOP;
            tx_q       <= 1'b1;
          end
          ST_STOP: begin
            if (tx_stop2_q && !tx_stop_second_q) tx_stop_second_q <= 1'b1;
            else                                 tx_state_q       <= ST_IDLE;
          end
          default: tx_state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser and FSM
  // ---------------------------------------------------------------------------
  logic rx_s1_q, rx_s2_q;

  // Two-flop synchroniser for the asynchronous serial input, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
    end
  end

  state_t                rx_state_q;
  logic [DIV_WIDTH-1:0]  rx_cnt_q, rx_div_q, rx_half;
  logic [3:0]            rx_bit_q, rx_nbits_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_par_en_q, rx_odd_q, rx_par_acc_q, rx_par_err_q;
  logic                  rx_sample, rx_push;

  // Sample point: half a bit after the falling edge, then one full bit apart
  always_comb begin
    rx_half = rx_div_q >> 1;
    if (rx_state_q == ST_START) rx_sample = (rx_cnt_q == rx_half - C_ONE);
    else                        rx_sample = (rx_cnt_q == rx_div_q - C_ONE);
  end

  assign rx_push = (rx_state_q == ST_STOP) && rx_sample;

  // Deserialise one frame; push at the first stop-bit sample
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= C_MIN_DIV;
      rx_bit_q     <= '0;
      rx_nbits_q   <= 4'd8;
      rx_data_q    <= '0;
      rx_par_en_q  <= 1'b0;
      rx_odd_q     <= 1'b0;
      rx_par_acc_q <= 1'b0;
      rx_par_err_q <= 1'b0;
    end else if (rx_state_q == ST_IDLE) begin
      if (!rx_s2_q) begin
        rx_state_q   <= ST_START;
        rx_cnt_q     <= '0;
        rx_div_q     <= div_eff;
        rx_bit_q     <= '0;
        rx_nbits_q   <= nbits_eff;
        rx_data_q    <= '0;
        rx_par_en_q  <= par_en_eff;
        rx_odd_q     <= par_odd_eff;
        rx_par_acc_q <= 1'b0;
        rx_par_err_q <= 1'b0;
      end
    end else if (!rx_sample) begin
      rx_cnt_q <= rx_cnt_q + C_ONE;
    end else begin
      rx_cnt_q <= '0;
      case (rx_state_q)
        ST_START: rx_state_q <= rx_s2_q ? ST_IDLE : ST_DATA;
        ST_DATA: begin
          if (rx_s2_q) rx_data_q <= rx_data_q | (C_DATA_ONE << rx_bit_q);
          rx_par_acc_q <= rx_par_acc_q ^ rx_s2_q;
          if (rx_bit_q == rx_nbits_q - 4'd1)
            rx_state_q <= rx_par_en_q ? ST_PARITY : ST_STOP;
          else
            rx_bit_q <= rx_bit_q + 4'd1;
        end
        ST_PARITY: begin
          rx_par_err_q <= rx_par_acc_q ^ rx_s2_q ^ rx_odd_q;
          rx_state_q   <= ST_STOP;
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [RW-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW:0]   rx_wr_q, rx_rd_q;
  logic          rx_empty, rx_full, rx_pop, rx_wr_en, rx_overrun_q;
  logic [RW-1:0] rx_head;

  assign rx_empty      = (rx_wr_q == rx_rd_q);
  assign rx_full       = (rx_wr_q[AW] != rx_rd_q[AW]) &&
                         (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign rx_pop        = m_axis_tvalid && m_axis_tready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands
  assign rx_wr_en      = rx_push && (!rx_full || rx_pop);
  assign rx_head       = rx_mem_q[rx_rd_q[AW-1:0]];
  assign m_axis_tvalid = !rx_empty;
  assign m_axis_tdata  = rx_empty ? '0 : rx_head[DATA_WIDTH-1:0];
  assign m_axis_tuser  = rx_empty ? 2'b00 : rx_head[RW-1:DATA_WIDTH];
  assign rx_overrun    = rx_overrun_q;

  // RX FIFO storage: {parity_err, frame_err, data}
  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem_q[rx_wr_q[AW-1:0]] <= {rx_par_err_q, !rx_s2_q, rx_data_q};
  end

  // RX FIFO pointers and overrun pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_wr_en) rx_wr_q <= rx_wr_q + C_PTR_ONE;
      if (rx_pop)   rx_rd_q <= rx_rd_q + C_PTR_ONE;
      rx_overrun_q <= rx_push && rx_full && !rx_pop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_axis_cfg_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_axis_cfg_bridge
// Description : Directed self-checking bench for uart_axis_cfg_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_axis_cfg_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div = 16'd8;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic [1:0]  cfg_parity = 2'b00;
  logic        cfg_stop2 = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        uart_rx;
  logic        uart_tx;
  logic        tx_busy;
  logic        rx_overrun;

  logic        lb = 1'b0;
  logic        rx_drv = 1'b1;
  assign uart_rx = lb ? uart_tx : rx_drv;

  int vectors = 0;
  int miscompares = 0;
  int ovr_cnt = 0;
  logic cap [256];

  uart_axis_cfg_bridge #(.DATA_WIDTH(8), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .tx_busy(tx_busy), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_overrun === 1'b1) ovr_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus / observation helpers (no checking) -------------
  task automatic push_tx(input logic [7:0] d);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  // Wait (bounded) for the start bit, then record uart_tx for ncyc cycles
  task automatic capture_tx(input int ncyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (uart_tx === 1'b0) begin found = 1'b1; break; end
      @(negedge clk);
    end
    if (found) begin
      for (int i = 0; i < ncyc; i++) begin
        cap[i] = uart_tx;
        @(negedge clk);
      end
    end
  endtask

  // Wait (bounded) for an RX byte and pop it
  task automatic read_rx(output logic [7:0] d, output logic [1:0] u, output bit ok);
    ok = 1'b0;
    d = 8'hxx;
    u = 2'bxx;
    for (int i = 0; i < 300; i++) begin
      if (m_axis_tvalid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      d = m_axis_tdata;
      u = m_axis_tuser;
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
    end
  endtask

  // Drive one serial frame onto uart_rx; a low stop bit is released just after its sample point
  task automatic send_rx(input logic [7:0] d, input int nbits, input bit par_en,
                         input bit par_bit, input bit stop_bit, input int div);
    rx_drv = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = d[i];
      repeat (div) @(negedge clk);
    end
    if (par_en) begin
      rx_drv = par_bit;
      repeat (div) @(negedge clk);
    end
    if (stop_bit) begin
      rx_drv = 1'b1;
      repeat (div) @(negedge clk);
    end else begin
      rx_drv = 1'b0;
      repeat (div / 2 + 1) @(negedge clk);
      rx_drv = 1'b1;
      repeat (div - div / 2 - 1) @(negedge clk);
    end
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_uart_tx: got %b want 1", uart_tx); end
    vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL reset_s_tready: got %b want 0", s_axis_tready); end
    vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid); end
    vectors++; if (m_axis_tdata !== 8'h00) begin miscompares++; $display("FAIL reset_m_tdata: got %h want 00", m_axis_tdata); end
    vectors++; if (m_axis_tuser !== 2'b00) begin miscompares++; $display("FAIL reset_m_tuser: got %b want 00", m_axis_tuser); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    vectors++; if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL reset_rx_overrun: got %b want 0", rx_overrun); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL release_s_tready: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_tx_8n1();
    logic [9:0] fr;
    logic [7:0] d;
    logic [1:0] u;
    bit ok;
    cfg_div = 16'd8; cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    lb = 1'b1;
    fr = {1'b1, 8'hA5, 1'b0};
    push_tx(8'hA5);
    vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL tx8n1_busy: got %b want 1", tx_busy); end
    capture_tx(80, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL tx8n1_start: got no start bit want start bit"); end
    if (ok) begin
      for (int i = 0; i < 80; i++) begin
        vectors++;
        if (cap[i] !== fr[i / 8]) begin miscompares++; $display("FAIL tx8n1_cycle%0d: got %b want %b", i, cap[i], fr[i / 8]); end
      end
    end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL tx8n1_idle_busy: got %b want 0", tx_busy); end
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL tx8n1_idle_tx: got %b want 1", uart_tx); end
    read_rx(d, u, ok);
    vectors++; if (!ok || d !== 8'hA5 || u !== 2'b00) begin miscompares++; $display("FAIL loop_a5: got ok=%0d data=%h user=%b want data=a5 user=00", ok, d, u); end
    lb = 1'b0;
  endtask

  task automatic test_parity();
    logic [9:0] fr;
    logic [7:0] d;
    logic [1:0] u;
    bit ok;
    cfg_div = 16'd8; cfg_data_bits = 4'd7; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    lb = 1'b1;
    // bit 7 of 0xB5 lies above the 7-bit frame and must not be sent
    fr = {1'b1, 1'b0, 7'h35, 1'b0};
    push_tx(8'hB5);
    capture_tx(80, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL tx7e1_start: got no start bit want start bit"); end
    if (ok) begin
      for (int i = 0; i < 80; i++) begin
        vectors++;
        if (cap[i] !== fr[i / 8]) begin miscompares++; $display("FAIL tx7e1_cycle%0d: got %b want %b", i, cap[i], fr[i / 8]); end
      end
    end
    read_rx(d, u, ok);
    vectors++; if (!ok || d !== 8'h35 || u !== 2'b00) begin miscompares++; $display("FAIL loop_7e1: got ok=%0d data=%h user=%b want data=35 user=00", ok, d, u); end
    lb = 1'b0;
    repeat (4) @(negedge clk);
    send_rx(8'h35, 7, 1'b1, 1'b1, 1'b1, 8);
    read_rx(d, u, ok);
    vectors++; if (!ok || d !== 8'h35 || u !== 2'b10) begin miscompares++; $display("FAIL rx_even_bad: got ok=%0d data=%h user=%b want data=35 user=10", ok, d, u); end
    cfg_parity = 2'b10;
    send_rx(8'h35, 7, 1'b1, 1'b1, 1'b1, 8);
    read_rx(d, u, ok);
    vectors++; if (!ok || d !== 8'h35 || u !== 2'b00) begin miscompares++; $display("FAIL rx_odd_ok: got ok=%0d data=%h user=%b want data=35 user=00", ok, d, u); end
    cfg_parity = 2'b00; cfg_data_bits = 4'd8;
  endtask

  task automatic test_break();
    logic [7:0] d;
    logic [1:0] u;
    bit ok;
    cfg_div = 16'd8; cfg_data_bits = 4'd8; cfg_parity = 2'b00;
    send_rx(8'h00, 8, 1'b0, 1'b0, 1'b0, 8);
    read_rx(d, u, ok);
    vectors++; if (!ok || d !== 8'h00 || u !== 2'b01) begin miscompares++; $display("FAIL rx_break: got ok=%0d data=%h user=%b want data=00 user=01", ok, d, u); end
    repeat (30) @(negedge clk);
    vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL break_no_extra: got tvalid=%b want 0", m_axis_tvalid); end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic [1:0] u;
    logic [7:0] bytes [5];
    bit ok;
    int base;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    base = ovr_cnt;
    for (int i = 0; i < 4; i++) send_rx(bytes[i], 8, 1'b0, 1'b0, 1'b1, 8);
    repeat (2) @(negedge clk);
    vectors++; if (ovr_cnt - base !== 0) begin miscompares++; $display("FAIL ovr_before_5th: got %0d pulses want 0", ovr_cnt - base); end
    send_rx(bytes[4], 8, 1'b0, 1'b0, 1'b1, 8);
    repeat (5) @(negedge clk);
    vectors++; if (ovr_cnt - base !== 1) begin miscompares++; $display("FAIL ovr_after_5th: got %0d pulses want 1", ovr_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      read_rx(d, u, ok);
      vectors++; if (!ok || d !== bytes[i] || u !== 2'b00) begin miscompares++; $display("FAIL ovr_read%0d: got ok=%0d data=%h user=%b want data=%h user=00", i, ok, d, u, bytes[i]); end
    end
    vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL ovr_drained: got tvalid=%b want 0", m_axis_tvalid); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic [1:0] u;
    bit ok;
    cfg_div = 16'd16; cfg_data_bits = 4'd8; cfg_parity = 2'b00;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL glitch_tvalid: got %b want 0", m_axis_tvalid); end
    send_rx(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
    read_rx(d, u, ok);
    vectors++; if (!ok || d !== 8'h5A || u !== 2'b00) begin miscompares++; $display("FAIL glitch_recover: got ok=%0d data=%h user=%b want data=5a user=00", ok, d, u); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] fr;
    logic [7:0] d;
    logic [1:0] u;
    bit ok;
    // out-of-range settings: divisor 2 -> 4, 15 data bits -> 8, parity 11 -> none
    cfg_div = 16'd2; cfg_data_bits = 4'd15; cfg_parity = 2'b11; cfg_stop2 = 1'b0;
    lb = 1'b1;
    fr = {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
    push_tx(8'h3C);
    push_tx(8'hC3);
    capture_tx(80, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_start: got no start bit want start bit"); end
    if (ok) begin
      for (int i = 0; i < 80; i++) begin
        vectors++;
        if (cap[i] !== fr[i / 4]) begin miscompares++; $display("FAIL b2b_cycle%0d: got %b want %b", i, cap[i], fr[i / 4]); end
      end
    end
    read_rx(d, u, ok);
    vectors++; if (!ok || d !== 8'h3C || u !== 2'b00) begin miscompares++; $display("FAIL b2b_rx0: got ok=%0d data=%h user=%b want data=3c user=00", ok, d, u); end
    read_rx(d, u, ok);
    vectors++; if (!ok || d !== 8'hC3 || u !== 2'b00) begin miscompares++; $display("FAIL b2b_rx1: got ok=%0d data=%h user=%b want data=c3 user=00", ok, d, u); end
    repeat (4) @(negedge clk);
    lb = 1'b0;
    cfg_data_bits = 4'd8; cfg_parity = 2'b00;
  endtask

  task automatic test_reset_mid_tx();
    bit ok;
    int base;
    cfg_div = 16'd8; cfg_data_bits = 4'd8; cfg_parity = 2'b00;
    lb = 1'b1;
    base = ovr_cnt;
    push_tx(8'h00);
    // 34 cycles after the start edge falls inside data bit 3
    capture_tx(34, ok);
    vectors++; if (!ok || uart_tx !== 1'b0) begin miscompares++; $display("FAIL midtx_bit3: got ok=%0d tx=%b want tx=0", ok, uart_tx); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL midtx_rst_tx: got %b want 1", uart_tx); end
    vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL midtx_rst_tready: got %b want 0", s_axis_tready); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL midtx_rst_busy: got %b want 0", tx_busy); end
    @(negedge clk);
    vectors++; if (s_axis_tready !== 1'b0) begin miscompares++; $display("FAIL midtx_rst_tready2: got %b want 0", s_axis_tready); end
    rst = 1'b0;
    repeat (100) @(negedge clk);
    vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL midtx_after_tvalid: got %b want 0", m_axis_tvalid); end
    vectors++; if (ovr_cnt - base !== 0) begin miscompares++; $display("FAIL midtx_overrun: got %0d pulses want 0", ovr_cnt - base); end
    vectors++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin miscompares++; $display("FAIL midtx_after_idle: got tx=%b busy=%b want tx=1 busy=0", uart_tx, tx_busy); end
    lb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_8n1();
    test_parity();
    test_break();
    test_overrun();
    test_glitch();
    test_back_to_back();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
